i2s_rx: RTL
===========

I2S_RX -- requirements
Module: i2s_rx

Interface
REQ-001 The block SHALL be parameterised as follows:
- DATA_W, default 24: output sample width, in bits.
- SLOT_BITS, default 32: expected bck cycles per channel slot.

REQ-002 The block SHALL have these ports (clock and reset first):
- clk, input, 1: single system clock; at least 4x the bck frequency.
- rst, input, 1: reset; synchronous, active-high.
- i2s_bck, input, 1: serial bit clock; asynchronous to clk.
- i2s_lrck, input, 1: word select; 0 = left, 1 = right; asynchronous.
- i2s_data, input, 1: serial data; MSB first; asynchronous.
- left_data, output, DATA_W: last complete left sample, two's complement.
- right_data, output, DATA_W: last complete right sample, two's complement.
- sample_valid, output, 1: one-clk pulse when left_data/right_data update.
- frame_err, output, 1: one-clk pulse on a slot-length mismatch (only when I2S_RX_FRAME_CHECK_EN is defined).

Function
REQ-003 Each of i2s_bck, i2s_lrck and i2s_data SHALL pass through a two-flop synchronizer in clk.
REQ-004 A bck rising event SHALL be flagged in the clk cycle where synchronized bck = 1 and its previous registered value = 0; all sampling of data and lrck occurs only in that cycle.
REQ-005 The protocol SHALL be Philips I2S: the data bit sampled at the first bck rising event after an lrck change is the LSB of the previous channel; the MSB of the new channel is sampled at the second event.
REQ-006 Within a slot, bit k (k = 0 for the MSB) SHALL be written to word position DATA_W-1-k while k < DATA_W.
REQ-007 Bits with k >= DATA_W SHALL be discarded.
REQ-008 Positions not written in a short slot SHALL be 0, i.e. the word is left-aligned.
REQ-009 On an lrck 0->1 boundary, the completed left word SHALL be moved to an internal left holding register.
REQ-010 On an lrck 1->0 boundary, left_data SHALL load the holding register, right_data SHALL load the completed right word, and sample_valid SHALL pulse high in the clk cycle after the boundary event.
REQ-011 The latency from an i2s_bck pin rising edge at a 1->0 boundary to sample_valid SHALL be at most 4 clk cycles.
REQ-012 left_data and right_data SHALL be stable at all times other than the sample_valid update cycle.
REQ-013 After reset, no sample_valid SHALL be issued until one complete left+right frame has been received following the first observed lrck 1->0 boundary; this prevents emitting a partial first frame.
REQ-014 The slot bit counter SHALL saturate at 63 and SHALL NOT wrap.
REQ-015 The slot bit counter SHALL clear to 1 at each lrck boundary event; the boundary bit counts as the previous slot's LSB.
REQ-016 If lrck changes without any intervening bck event, the block SHALL record no boundary, and the change SHALL be evaluated at the next bck rising event.

Reset
REQ-017 While rst is high, all synchronizers, counters, shift registers and holding registers SHALL clear to 0.
REQ-018 While rst is high, left_data = 0, right_data = 0, sample_valid = 0, frame_err = 0, and the frame-synced flag is cleared.
REQ-019 Reset asserted mid-slot SHALL discard the partial word; reception restarts per REQ-013.

Configuration
REQ-020 The macro I2S_RX_FRAME_CHECK_EN SHALL control frame checking.
- Defined: at each boundary event, if the completed slot's bit count != SLOT_BITS (the boundary LSB included), frame_err SHALL pulse for one clk, aligned with the boundary event plus 1 cycle. The sample is still delivered.
- Undefined: frame_err SHALL be tied to 0 and no compare logic SHALL be synthesized.

Structure
REQ-021 The shared package i2s_pkg SHALL hold the default DATA_W and SLOT_BITS constants, the counter width (6) and the lrck channel encoding constants (LEFT = 0, RIGHT = 1).
REQ-022 Synchronizing and edge detection SHALL be one sub-module, i2s_rx_sync (two-flop sync plus rise detect), instantiated once per input; the rest is flat.

Verification
REQ-023 The bench SHALL cover the following directed scenarios:
- Nominal frame: DATA_W = 24, SLOT_BITS = 32, clk = 8x bck; send left 24'h123456 and right 24'hABCDEF, zero-padded to 32 bits -> after the sync frame, left_data = 24'h123456, right_data = 24'hABCDEF, exactly one sample_valid per frame.
- Startup: begin streaming mid-right-slot after reset -> no sample_valid until the first full left+right pair; first outputs match the transmitted pair.
- Short slot: SLOT_BITS = 16 framing with left 16'h8001 -> left_data = 24'h800100; with the check enabled, frame_err pulses once per slot.
- Long slot: 32-bit words, DATA_W = 24, left 32'h7FFFFF55 -> left_data = 24'h7FFFFF (low 8 bits discarded), no frame_err.
- Reset mid-frame: assert rst for 2 clk during the left slot -> outputs read 0; the next valid pair appears only after a full resync frame.
- Clock ratio: clk = 4x bck with jitter of +/-1 clk on the bck edges -> no bit errors over 1000 random frames.

Source files
------------

// File: rtl/i2s_pkg.sv
// Shared constants for the I2S receiver: default widths, slot counter sizing,
// lrck channel encoding and the frame-lock state type.
package i2s_pkg;

    localparam int unsigned DATA_W_DEF    = 32'd24;
    localparam int unsigned SLOT_BITS_DEF = 32'd32;
    localparam int unsigned CNT_W         = 32'd6;

    localparam logic [CNT_W-1:0] CNT_MAX = 6'd63;

    localparam logic LRCK_LEFT  = 1'b0;
    localparam logic LRCK_RIGHT = 1'b1;

    typedef enum logic [0:0] {
        ST_HUNT   = 1'b0,
        ST_LOCKED = 1'b1
    } rx_state_e;

endpackage

// File: rtl/i2s_rx_sync.sv
// Two-flop synchronizer for one asynchronous I2S pin, with a rising-edge
// flag taken between the synchronized level and its registered copy.
module i2s_rx_sync (
    input  logic clk,
    input  logic rst,
    input  logic async_i,
    output logic level_o,
    output logic rise_o
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    // Synchronizer chain plus one extra stage for edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= async_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign level_o = sync_q;
    assign rise_o  = sync_q & ~prev_q;

endmodule

// File: rtl/i2s_rx.sv
// Philips I2S receiver oversampling bck/lrck/data in the clk domain.
// Define I2S_RX_FRAME_CHECK_EN to enable slot-length checking on frame_err.
module i2s_rx
    import i2s_pkg::*;
#(
    parameter int unsigned DATA_W    = DATA_W_DEF,
    parameter int unsigned SLOT_BITS = SLOT_BITS_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i2s_bck,
    input  logic              i2s_lrck,
    input  logic              i2s_data,
    output logic [DATA_W-1:0] left_data,
    output logic [DATA_W-1:0] right_data,
    output logic              sample_valid,
    output logic              frame_err
);

    // Bit indices never exceed 62, so a wider word accepts every bit.
    localparam logic [CNT_W-1:0] DW_C = (DATA_W > 32'd63) ? CNT_MAX : CNT_W'(DATA_W);

    logic bck_rise_s;
    logic lrck_s;
    logic data_s;
    logic bck_level_unused;
    logic lrck_rise_unused;
    logic data_rise_unused;

    i2s_rx_sync u_sync_bck (
        .clk     (clk),
        .rst     (rst),
        .async_i (i2s_bck),
        .level_o (bck_level_unused),
        .rise_o  (bck_rise_s)
    );

    i2s_rx_sync u_sync_lrck (
        .clk     (clk),
        .rst     (rst),
        .async_i (i2s_lrck),
        .level_o (lrck_s),
        .rise_o  (lrck_rise_unused)
    );

    i2s_rx_sync u_sync_data (
        .clk     (clk),
        .rst     (rst),
        .async_i (i2s_data),
        .level_o (data_s),
        .rise_o  (data_rise_unused)
    );

    rx_state_e         state_q,     state_d;
    logic              lrck_prev_q, lrck_prev_d;
    logic [CNT_W-1:0]  cnt_q,       cnt_d;
    logic [DATA_W-1:0] word_q,      word_d;
    logic [DATA_W-1:0] hold_q,      hold_d;
    logic [DATA_W-1:0] left_q,      left_d;
    logic [DATA_W-1:0] right_q,     right_d;
    logic              valid_q,     valid_d;

    logic              boundary_s;
    logic              wr_en_s;
    logic [CNT_W-1:0]  bit_idx_s;
    logic [DATA_W-1:0] word_wr_s;

    // cnt_q == 0 means no boundary seen since reset; nothing is written then.
    assign boundary_s = bck_rise_s & (lrck_s != lrck_prev_q);
    assign bit_idx_s  = cnt_q - 6'd1;
    assign wr_en_s    = bck_rise_s & (cnt_q != 6'd0) & (bit_idx_s < DW_C);

    // Current word with this event's bit dropped into its left-aligned slot.
    always_comb begin
        word_wr_s = word_q;
        for (int i = 0; i < int'(DATA_W); i++) begin
            word_wr_s[i] = (wr_en_s && (i == int'(DATA_W) - 1 - int'(bit_idx_s))) ? data_s : word_q[i];
        end
    end

    // Slot tracking, channel hand-off and frame-lock state machine.
    always_comb begin
        state_d     = state_q;
        lrck_prev_d = lrck_prev_q;
        cnt_d       = cnt_q;
        word_d      = word_q;
        hold_d      = hold_q;
        left_d      = left_q;
        right_d     = right_q;
        valid_d     = 1'b0;
        if (boundary_s) begin
            lrck_prev_d = lrck_s;
            cnt_d       = 6'd1;
            word_d      = {DATA_W{1'b0}};
            if (lrck_s == LRCK_RIGHT) begin
                hold_d = word_wr_s;
            end else begin
                case (state_q)
                    ST_HUNT: begin
                        state_d = ST_LOCKED;
                    end
                    ST_LOCKED: begin
                        left_d  = hold_q;
                        right_d = word_wr_s;
                        valid_d = 1'b1;
                    end
                    default: begin
                        state_d = ST_HUNT;
                    end
                endcase
            end
        end else if (bck_rise_s) begin
            word_d = word_wr_s;
            cnt_d  = ((cnt_q == 6'd0) || (cnt_q == CNT_MAX)) ? cnt_q : cnt_q + 6'd1;
        end else begin
            word_d = word_q;
        end
    end

    // State registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_HUNT;
            lrck_prev_q <= 1'b0;
            cnt_q       <= 6'd0;
            word_q      <= {DATA_W{1'b0}};
            hold_q      <= {DATA_W{1'b0}};
            left_q      <= {DATA_W{1'b0}};
            right_q     <= {DATA_W{1'b0}};
            valid_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            lrck_prev_q <= lrck_prev_d;
            cnt_q       <= cnt_d;
            word_q      <= word_d;
            hold_q      <= hold_d;
            left_q      <= left_d;
            right_q     <= right_d;
            valid_q     <= valid_d;
        end
    end

    assign left_data    = left_q;
    assign right_data   = right_q;
    assign sample_valid = valid_q;

`ifdef I2S_RX_FRAME_CHECK_EN
    localparam logic [CNT_W-1:0] SLOT_C = (SLOT_BITS > 32'd63) ? CNT_MAX : CNT_W'(SLOT_BITS);

    logic ferr_q, ferr_d;

    // The first slot after reset is partial by construction and is not judged.
    always_comb begin
        ferr_d = 1'b0;
        if (boundary_s && (cnt_q != 6'd0)) begin
            ferr_d = (cnt_q != SLOT_C);
        end else begin
            ferr_d = 1'b0;
        end
    end

    // Frame error pulse register.
    always_ff @(posedge clk) begin
        if (rst) begin
            ferr_q <= 1'b0;
        end else begin
            ferr_q <= ferr_d;
        end
    end

    assign frame_err = ferr_q;
`else
    localparam int unsigned SLOT_BITS_unused = SLOT_BITS;

    assign frame_err = 1'b0;
`endif

endmodule
